regfile_param: RTL and testbench
================================

# regfile_param

Parametrised register file for the ID stage. It has one write port with byte enables and `NUM_RD` combinational read ports. Register 0 can optionally be hard-wired to zero, and write-to-read forwarding is optional. A synchronous reset starts a one-entry-per-cycle clear sweep, so the array can map onto RAM-style storage; a `ready` flag reports when the sweep is done. This block replaces the fixed 32x32, two-read register file.

## Interface
- `DATA_W`, 32, register width in bits; must be a multiple of 8.
- `ADDR_W`, 5, address width; depth is `DEPTH = 2**ADDR_W`.
- `NUM_RD`, 2, number of read ports; must be at least 1.
- `ZERO_REG`, 1, when 1, register 0 reads as 0 and writes to it are discarded.
- `BYPASS`, 1, when 1, a same-cycle write is forwarded to matching read ports.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `RW`  in  ADDR_W  write address.
- `RegWrite`  in  1  write strobe.
- `WBE`  in  DATA_W/8  byte enables for the write; bit i covers `busW[8i+7:8i]`.
- `busW`  in  DATA_W  write data.
- `RADDR`  in  NUM_RD*ADDR_W  packed read addresses; port p uses slice `[p*ADDR_W +: ADDR_W]`.
- `RDATA`  out  NUM_RD*DATA_W  packed read data; port p uses slice `[p*DATA_W +: DATA_W]`.
- `ready`  out  1  high once the clear sweep has finished.
- `wr_drop`  out  1  registered one-cycle pulse flagging a write that was discarded because `ready` was low.

## Operation
- **States:** the block has two states, CLEAR and READY, plus a clear pointer `clr_ptr` of ADDR_W bits.
- **Reset:** while `reset` is high:
  - state is forced to CLEAR, `clr_ptr` to 0 and `wr_drop` to 0;
  - no array entry is written.
- **CLEAR state** (with `reset` low), each cycle:
  - `mem[clr_ptr]` is set to 0;
  - if `clr_ptr == DEPTH-1`, the next state is READY;
  - otherwise `clr_ptr` increments.
- **READY state:** the block stays in READY until `reset` is asserted again. Asserting `reset` mid-sweep or mid-operation restarts the sweep from entry 0.
- **`ready`:** equals 1 exactly when the state is READY.
- **Write:** when `RegWrite & ready` is true, each byte i with `WBE[i]=1` is updated from `busW` at `mem[RW]`. Unenabled bytes keep their old value. With `WBE=0` nothing changes.
  - If `ZERO_REG=1` and `RW==0`, the write is silently discarded. This does not raise `wr_drop`.
- **Dropped writes:** when `RegWrite & ~ready` is true, `wr_drop` is 1 on the next cycle. The write is not performed and is never replayed.
- **Read, per port p (combinational), in priority order:**
  1. If `ready` is low, the result is 0.
  2. Otherwise, if `ZERO_REG=1` and `RADDR_p == 0`, the result is 0.
  3. Otherwise, if `BYPASS=1`, `RegWrite=1` and `RW == RADDR_p`, the result is the merged value: byte i comes from `busW` if `WBE[i]=1`, else from `mem[RADDR_p]`.
  4. Otherwise, the result is `mem[RADDR_p]`.
- **Multiple ports:** several ports may read the same address in the same cycle, and all see identical data.
- **Widths:** there is no arithmetic. Indices are unsigned and every address is in range, so there is no out-of-range case.

## Timing
- **Reset values:** `ready`=0, `wr_drop`=0, and every `RDATA` slice is 0 because reads are forced to 0 while not ready.
- **Sweep length:** from the first rising edge with `reset` low, the sweep takes exactly `DEPTH` cycles. `ready` rises after edge `DEPTH` (cycle 32 with the default parameters).
- **Write latency:** the written data is visible on a read with `BYPASS=0` in the cycle after the write edge. With `BYPASS=1` it is visible in the same cycle, combinationally.
- **Read path:** read ports have no clocked latency; the path is purely combinational from `RADDR`, `RW`, `RegWrite`, `WBE`, `busW` and the state.
- **`wr_drop`:** a registered pulse, asserted on the cycle after the offending `RegWrite`. It is high for one cycle per dropped write, and consecutive drops hold it high.
- **Write in the final clear cycle:** a write in the cycle where the state is CLEAR and `clr_ptr == DEPTH-1` is dropped and flagged.
- **Write on the first READY cycle:** this write is accepted.

## Test plan
- **Reset sweep:** pulse `reset` for 3 cycles, then release, with default parameters. Required: `ready`=0 for 32 cycles and 1 from cycle 33; every `RDATA` is 0 throughout; reading all 32 addresses afterwards returns 0.
- **Write and read:** write `RW=5`, `busW=0xDEADBEEF`, `WBE=0xF`, with `RADDR` port 0 = 5.
  - With `BYPASS=1`: `RDATA` port 0 = 0xDEADBEEF in the same cycle.
  - With `BYPASS=0`: 0xDEADBEEF appears on the next cycle.
- **Byte enables:** write 0x11223344 to reg 7, then write `busW=0xAABBCCDD` with `WBE=0b0101`. Required: reg 7 reads 0x11BB33DD, and the bypass value in the write cycle equals 0x11BB33DD.
- **Zero register:** with `ZERO_REG=1`, write 0xFFFFFFFF to reg 0. Required: reg 0 reads 0 and `wr_drop` stays 0. With `ZERO_REG=0`, the same write makes reg 0 read 0xFFFFFFFF.
- **Writes while not ready:** assert `RegWrite` at sweep cycle 10. Required: `wr_drop`=1 at cycle 11 and the target reads 0 after `ready` rises.
  - Then, after `ready`, write reg 3 = 0x55, assert `reset` for 1 cycle and release. Required: `ready` drops, the sweep restarts, and reg 3 reads 0 afterwards.
- **Multi-port reads:** set `NUM_RD=4` and point all ports at reg 9, which holds 0x1234. Required: all four slices read 0x1234 in the same cycle.

Source files
------------

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file with byte-enable write, N read ports and clear sweep
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        RW,
    input  logic                     RegWrite,
    input  logic [DATA_W/8-1:0]      WBE,
    input  logic [DATA_W-1:0]        busW,
    input  logic [NUM_RD*ADDR_W-1:0] RADDR,
    output logic [NUM_RD*DATA_W-1:0] RDATA,
    output logic                     ready,
    output logic                     wr_drop
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_next;
    logic              wr_en;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            wr_drop <= 1'b0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
            wr_drop <= RegWrite & ~ready;
        end
    end

    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        if (state == CLEAR) begin
            if (clr_ptr == {ADDR_W{1'b1}}) begin
                state_next = READY;
            end else begin
                clr_ptr_next = clr_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        ready = (state == READY);
        wr_en = RegWrite & ready & ~((ZERO_REG != 0) && (RW == '0));
    end

    // One entry per cycle, never written while reset is held, so this maps onto RAM storage
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (wr_en) begin
                for (int i = 0; i < NB; i++) begin
                    if (WBE[i]) begin
                        mem[RW][8*i +: 8] <= busW[8*i +: 8];
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] stored;
        logic [DATA_W-1:0] merged;
        logic              hit;

        assign addr   = RADDR[p*ADDR_W +: ADDR_W];
        assign stored = mem[addr];
        assign hit    = (BYPASS != 0) && RegWrite && (RW == addr);

        for (genvar b = 0; b < NB; b++) begin : g_byte
            assign merged[8*b +: 8] = WBE[b] ? busW[8*b +: 8] : stored[8*b +: 8];
        end

        assign RDATA[p*DATA_W +: DATA_W] =
            (!ready)                                ? '0 :
            ((ZERO_REG != 0) && (addr == '0))       ? '0 :
            hit                                     ? merged :
                                                      stored;
    end
endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - directed self-checking bench for regfile_param (default and no-bypass/no-zero/4-port builds)
module tb_regfile_param;
    logic         clk = 1'b0;
    logic         reset;
    logic [4:0]   rw;
    logic         reg_write;
    logic [3:0]   wbe;
    logic [31:0]  bus_w;
    logic [9:0]   raddr_a;
    logic [19:0]  raddr_b;
    logic [63:0]  rdata_a;
    logic [127:0] rdata_b;
    logic         ready_a, ready_b, drop_a, drop_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_param dut_a (
        .clk(clk), .reset(reset), .RW(rw), .RegWrite(reg_write), .WBE(wbe), .busW(bus_w),
        .RADDR(raddr_a), .RDATA(rdata_a), .ready(ready_a), .wr_drop(drop_a)
    );

    regfile_param #(.NUM_RD(4), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .RW(rw), .RegWrite(reg_write), .WBE(wbe), .busW(bus_w),
        .RADDR(raddr_b), .RDATA(rdata_b), .ready(ready_b), .wr_drop(drop_b)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a);
        raddr_a = {a, a};
        raddr_b = {a, a, a, a};
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        rw = a; bus_w = d; wbe = be; reg_write = 1'b1;
        tick;
        reg_write = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; rw = '0; reg_write = 1'b0; wbe = '0; bus_w = '0;
        raddr_a = '0; raddr_b = '0;
        repeat (3) tick;
        check("reset_ready", {ready_a, ready_b}, 2'b00);
        check("reset_drop", {drop_a, drop_b}, 2'b00);
        check("reset_rdata_a", rdata_a, 64'h0);
        check("reset_rdata_b", rdata_b, 128'h0);

        // Sweep: writes before edges 10 and 32 land in CLEAR and must be dropped
        reset = 1'b0;
        rw = 5'd12; bus_w = 32'hCAFE_F00D; wbe = 4'hF;
        for (int c = 1; c <= 32; c++) begin
            set_rd(5'(c - 1));
            reg_write = (c == 10) || (c == 32);
            #1;
            check("sweep_rdata_a", rdata_a, 64'h0);
            check("sweep_rdata_b", rdata_b, 128'h0);
            tick;
            check("sweep_ready_a", ready_a, (c == 32));
            check("sweep_ready_b", ready_b, (c == 32));
            check("sweep_drop_a", drop_a, (c == 10) || (c == 32));
            check("sweep_drop_b", drop_b, (c == 10) || (c == 32));
        end
        reg_write = 1'b0;
        tick;
        check("drop_clears", {drop_a, drop_b}, 2'b00);
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a));
            #1;
            check("post_sweep_a", rdata_a, 64'h0);
            check("post_sweep_b", rdata_b, 128'h0);
        end

        // Bypass visible same cycle on dut_a, next cycle on dut_b
        set_rd(5'd5);
        rw = 5'd5; bus_w = 32'hDEAD_BEEF; wbe = 4'hF; reg_write = 1'b1;
        #1;
        check("bypass_same_cycle", rdata_a[31:0], 32'hDEAD_BEEF);
        check("nobypass_same_cycle", rdata_b[31:0], 32'h0);
        tick;
        reg_write = 1'b0;
        #1;
        check("wr_next_cycle_a", rdata_a[31:0], 32'hDEAD_BEEF);
        check("wr_next_cycle_b", rdata_b[31:0], 32'hDEAD_BEEF);
        check("first_write_no_drop", {drop_a, drop_b}, 2'b00);

        write(5'd7, 32'h1122_3344, 4'hF);
        set_rd(5'd7);
        rw = 5'd7; bus_w = 32'hAABB_CCDD; wbe = 4'b0101; reg_write = 1'b1;
        #1;
        check("be_bypass_merge", rdata_a[31:0], 32'h11BB_33DD);
        check("be_nobypass_old", rdata_b[31:0], 32'h1122_3344);
        tick;
        reg_write = 1'b0;
        #1;
        check("be_stored_a", rdata_a[31:0], 32'h11BB_33DD);
        check("be_stored_b", rdata_b[31:0], 32'h11BB_33DD);

        raddr_a = {5'd7, 5'd5};
        #1;
        check("two_port_distinct", rdata_a, {32'h11BB_33DD, 32'hDEAD_BEEF});

        // Register 0: hard-wired on dut_a, ordinary on dut_b
        set_rd(5'd0);
        rw = 5'd0; bus_w = 32'hFFFF_FFFF; wbe = 4'hF; reg_write = 1'b1;
        #1;
        check("zero_bypass_a", rdata_a[31:0], 32'h0);
        tick;
        reg_write = 1'b0;
        #1;
        check("zero_drop", {drop_a, drop_b}, 2'b00);
        check("zero_reg_a", rdata_a, 64'h0);
        check("zero_reg_b", rdata_b[31:0], 32'hFFFF_FFFF);

        write(5'd9, 32'h0000_1234, 4'hF);
        set_rd(5'd9);
        #1;
        check("multi_port_b", rdata_b, {4{32'h0000_1234}});
        check("multi_port_a", rdata_a, {2{32'h0000_1234}});

        set_rd(5'd12);
        #1;
        check("dropped_target_a", rdata_a[31:0], 32'h0);
        check("dropped_target_b", rdata_b[31:0], 32'h0);

        // Reset mid-operation restarts the sweep and wipes earlier writes
        write(5'd3, 32'h0000_0055, 4'hF);
        set_rd(5'd3);
        #1;
        check("reg3_written", rdata_b[31:0], 32'h55);
        reset = 1'b1;
        tick;
        check("rst_again_ready", {ready_a, ready_b}, 2'b00);
        check("rst_again_rdata", rdata_b, 128'h0);
        reset = 1'b0;
        repeat (31) tick;
        check("resweep_not_ready", {ready_a, ready_b}, 2'b00);
        tick;
        check("resweep_ready", {ready_a, ready_b}, 2'b11);
        check("reg3_cleared_a", rdata_a[31:0], 32'h0);
        check("reg3_cleared_b", rdata_b[31:0], 32'h0);
        set_rd(5'd5);
        #1;
        check("reg5_cleared", rdata_b[31:0], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
